pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96: width of the datapath payload (PC, IR, operands, immediate).
REQ-002 Parameter CTRL_W, default 8: width of the control-signal bundle.
REQ-003 Parameter CTRL_KEEP_MASK, default {CTRL_W{1'b0}}: control bits that are preserved through bubbles and flushes; all other bits are forced to 0.
REQ-004 clock  in  1  single clock for the block; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream entry present.
REQ-007 in_ready  out  1  stage accepts the entry this cycle.
REQ-008 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 out_valid  out  1  output entry present.
REQ-011 out_ready  in  1  downstream consumes the entry this cycle.
REQ-012 out_ctrl  out  CTRL_W  control bundle to downstream.
REQ-013 out_data  out  DATA_W  payload to downstream.
REQ-014 flush  in  1  synchronous kill of all held and incoming entries.
REQ-015 hazard  in  1  hazard unit requests bubble insertion; upstream is held.

Function
REQ-016 Storage is a main register plus one skid register, each with a valid bit, control and payload fields.
REQ-017 States: EMPTY (no valid entry), FULL (main only), SKID (main and skid).
REQ-018 in_ready = !skid_valid && !hazard, combinational and independent of in_valid.
REQ-019 Accept = in_valid && in_ready; consume = out_valid && out_ready.
REQ-020 EMPTY: on accept, load main and go to FULL; otherwise stay in EMPTY.
REQ-021 FULL: accept+consume loads main and stays FULL; accept only loads skid and goes to SKID; consume only goes to EMPTY; neither holds main.
REQ-022 SKID: on consume, move skid into main and go to FULL; otherwise hold both; in_ready=0.
REQ-023 out_valid = main_valid; out_data = main payload; out_ctrl = main_valid ? main ctrl : (main ctrl & CTRL_KEEP_MASK).
REQ-024 Latency is 1 cycle from accept to out_valid when the stage is EMPTY; throughput is 1 entry per cycle while out_ready=1.
REQ-025 While out_valid=1 && out_ready=0, out_ctrl and out_data shall remain stable.
REQ-026 Hazard forces in_ready=0 only; held entries still drain normally, and output becomes a bubble once the stage is empty.
REQ-027 Flush has top priority: both valid bits clear and the state goes to EMPTY at the next edge; stored ctrl becomes ctrl & CTRL_KEEP_MASK; payload is unchanged; an input offered in the flush cycle is dropped.
REQ-028 Flush and consume in the same cycle: the downstream consume is honoured and the stage still ends in EMPTY.
REQ-029 Order is preserved; no entry is duplicated or lost except by flush.

Reset
REQ-030 Asserting reset (low), at any time including mid-transfer, clears main_valid and skid_valid, all ctrl and payload fields, and any counters to 0.
REQ-031 During and after reset, out_valid=0 and out_ctrl=0, and in_ready=!hazard.

Configuration
REQ-032 Macro PIPE_STAGE_PERF_EN, when defined, adds outputs bubble_cnt[15:0] (cycles with out_valid=0) and stall_cnt[15:0] (cycles with out_valid && !out_ready).
REQ-033 Both counters saturate at 16'hFFFF and are cleared by reset; flush does not clear them.
REQ-034 Without PIPE_STAGE_PERF_EN, the counter ports and logic are absent and behaviour is otherwise identical.

Verification
REQ-035 Streaming: CTRL_W=8, out_ready=1, in_valid=1 with data 1..5 -> out_data is 1..5 on consecutive cycles starting 1 cycle later, with no gaps.
REQ-036 Backpressure: out_ready=0 for 3 cycles while data A,B are offered -> state reaches SKID, in_ready=0, out_data=A held; after out_ready=1, A then B are emitted.
REQ-037 Flush in SKID: ctrl=8'hFF, CTRL_KEEP_MASK=8'h10, flush=1 -> next cycle out_valid=0, out_ctrl=8'h10, in_ready=1.
REQ-038 Hazard: hazard=1 for 2 cycles with a full stage and out_ready=1 -> 1 entry drains, then out_valid=0 and out_ctrl=ctrl & mask; upstream entry held unaccepted.
REQ-039 Async reset mid-SKID: reset low between edges -> out_valid=0 and out_ctrl=0 immediately, without waiting for a clock edge.
REQ-040 PIPE_STAGE_PERF_EN defined: 70000 idle cycles -> bubble_cnt=16'hFFFF and stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a pipeline register stage with a skid buffer, flush and hazard
// bubble insertion. The main register feeds the output. The skid register catches
// the one entry that is accepted while downstream stalls.
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating bubble_cnt
// and stall_cnt performance counters.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W         = 96,
    parameter int unsigned          CTRL_W         = 8,
    parameter logic [CTRL_W-1:0]    CTRL_KEEP_MASK = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              hazard
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_consume;

    // The valid bits follow from the state encoding, so they cannot disagree with it
    assign w_main_valid = (r_state == FULL) || (r_state == SKID);
    assign w_skid_valid = (r_state == SKID);

    // in_ready does not look at in_valid, which avoids a combinational loop with upstream
    assign in_ready  = !w_skid_valid && !hazard;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = w_main_valid && out_ready;

    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = w_main_valid ? r_main_ctrl : (r_main_ctrl & CTRL_KEEP_MASK);

    // Stage FSM and storage: flush wins over everything; consume in the flush cycle still completes downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_main_ctrl <= r_main_ctrl & CTRL_KEEP_MASK;
            r_skid_ctrl <= r_skid_ctrl & CTRL_KEEP_MASK;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                        r_state     <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_consume) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                    end else if (w_accept) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                        r_state     <= SKID;
                    end else if (w_consume) begin
                        r_state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_consume) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_state     <= FULL;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating occupancy counters; flush does not clear them, so they span whole runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (!w_main_valid && (r_bubble_cnt != 16'hFFFF))
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            if (w_main_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. A queue holds the entries the stage should be
// carrying. Each entry is pushed when the stage should accept it, and popped and
// compared when downstream consumes it.
module tb_pipe_stage_reg;

    localparam int unsigned       DATA_W = 96;
    localparam int unsigned       CTRL_W = 8;
    localparam logic [CTRL_W-1:0] MASK   = 8'h10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready, flush, hazard;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]       bubble_cnt, stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [CTRL_W+DATA_W-1:0] q[$];

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_KEEP_MASK(MASK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .hazard(hazard)
`ifdef PIPE_STAGE_PERF_EN
        , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs already driven. The model checks handshake
    // outputs, scores any consume, then records any accept and advances past the edge.
    task automatic cyc();
        logic acc;
        logic [CTRL_W+DATA_W-1:0] e;
        #1;
        acc = in_valid && (q.size() < 2) && !hazard;
        chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
        chk("in_ready", {127'd0, in_ready}, {127'd0, acc || (!in_valid && q.size() < 2 && !hazard)});
        if (out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", {32'd0, out_data}, {32'd0, e[DATA_W-1:0]});
            chk("out_ctrl", {120'd0, out_ctrl}, {120'd0, e[CTRL_W+DATA_W-1:DATA_W]});
        end
        if (flush) q.delete();
        else if (acc) q.push_back({in_ctrl, in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0; hazard = 1'b0;
        #12;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_ctrl", {120'd0, out_ctrl}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        hazard = 1'b1; #1;
        chk("rst_in_ready_hz", {127'd0, in_ready}, 128'd0);
        hazard = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming 1..5 with out_ready held high: no gaps, one cycle of latency
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            offer(1'b1, 8'hA0 + 8'(i), DATA_W'(i));
            cyc();
            chk("stream_data", {32'd0, out_data}, 128'(i));
        end
        offer(1'b0, '0, '0);
        cyc();

        // Backpressure: A then B with out_ready low reaches SKID and holds A
        out_ready = 1'b0;
        offer(1'b1, 8'h11, 96'hA);
        cyc();
        offer(1'b1, 8'h22, 96'hB);
        cyc();
        offer(1'b1, 8'h33, 96'hC);
        cyc();
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        chk("bp_hold_a", {32'd0, out_data}, 128'hA);
        chk("bp_hold_ctrl", {120'd0, out_ctrl}, 128'h11);
        offer(1'b0, '0, '0);
        out_ready = 1'b1;
        cyc();
        chk("bp_then_b", {32'd0, out_data}, 128'hB);
        cyc();
        cyc();

        // Flush in SKID with ctrl FF: kept bit survives, stage empties, in_ready returns
        out_ready = 1'b0;
        offer(1'b1, 8'hFF, 96'h100);
        cyc();
        offer(1'b1, 8'hFF, 96'h101);
        cyc();
        offer(1'b1, 8'hFF, 96'h102);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        chk("fl_out_valid", {127'd0, out_valid}, 128'd0);
        chk("fl_out_ctrl", {120'd0, out_ctrl}, 128'h10);
        chk("fl_in_ready", {127'd0, in_ready}, 128'd1);
        cyc();

        // Flush together with consume: the entry goes downstream, and the stage still empties
        offer(1'b1, 8'h44, 96'h200);
        cyc();
        out_ready = 1'b1;
        flush = 1'b1;
        offer(1'b1, 8'h45, 96'h201);
        cyc();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        chk("flc_out_valid", {127'd0, out_valid}, 128'd0);

        // Hazard with a full stage: one entry drains, then a bubble; upstream is held
        out_ready = 1'b0;
        offer(1'b1, 8'h3F, 96'h300);
        cyc();
        hazard = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 8'h55, 96'h301);
        cyc();
        chk("hz_bubble", {127'd0, out_valid}, 128'd0);
        chk("hz_ctrl", {120'd0, out_ctrl}, 128'h10);
        cyc();
        chk("hz_held", {127'd0, in_ready}, 128'd0);
        hazard = 1'b0;
        cyc();
        offer(1'b0, '0, '0);
        chk("hz_release", {32'd0, out_data}, 128'h301);
        cyc();

        // Asynchronous reset between edges while in SKID
        out_ready = 1'b0;
        offer(1'b1, 8'h66, 96'h400);
        cyc();
        offer(1'b1, 8'h77, 96'h401);
        cyc();
        offer(1'b0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {127'd0, out_valid}, 128'd0);
        chk("ar_out_ctrl", {120'd0, out_ctrl}, 128'd0);
        chk("ar_out_data", {32'd0, out_data}, 128'd0);
        chk("ar_in_ready", {127'd0, in_ready}, 128'd1);
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc();

`ifdef PIPE_STAGE_PERF_EN
        // Idle soak past the counter range: bubble_cnt saturates and stall_cnt never moves
        rst_n = 1'b0; #3; rst_n = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("perf_bubble", {112'd0, bubble_cnt}, 128'hFFFF);
        chk("perf_stall", {112'd0, stall_cnt}, 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
